// File: rtl/ls165.sv
// rtl/ls165.sv - LS165-style parallel-in/serial-out shift register
// Stage A is q[0] (serial in), stage H is q[WIDTH-1] (serial out); load is synchronous.
module ls165 #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             SH_LD_n,
    input  logic             CLK_INH,
    input  logic             SER,
    input  logic [WIDTH-1:0] D,
    output logic             QH,
    output logic             QH_n
);

    logic [WIDTH-1:0] q;

    // Priority: clear > load > inhibit > shift toward H.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            q <= '0;
        end else if (!SH_LD_n) begin
            q <= D;
        end else if (!CLK_INH) begin
            q <= {q[WIDTH-2:0], SER};
        end
    end

    assign QH   = q[WIDTH-1];
    assign QH_n = ~q[WIDTH-1];

endmodule

// File: tb/tb_ls165.sv
// tb/tb_ls165.sv - directed vector bench for ls165
module tb_ls165;

    logic       CLK = 1'b0;
    logic       CLR = 1'b0;
    logic       SH_LD_n = 1'b1;
    logic       CLK_INH = 1'b0;
    logic       SER = 1'b0;
    logic [7:0] D = 8'h00;
    logic       QH, QH_n;

    logic       c_clr = 1'b0;
    logic       c_ld_n = 1'b1;
    logic [7:0] c_da = 8'h00;
    logic [7:0] c_db = 8'h00;
    logic       a_qh, a_qh_n, b_qh, b_qh_n;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    ls165 #(.WIDTH(8)) dut (
        .CLK(CLK), .CLR(CLR), .SH_LD_n(SH_LD_n), .CLK_INH(CLK_INH),
        .SER(SER), .D(D), .QH(QH), .QH_n(QH_n)
    );

    ls165 #(.WIDTH(8)) u_a (
        .CLK(CLK), .CLR(c_clr), .SH_LD_n(c_ld_n), .CLK_INH(1'b0),
        .SER(1'b0), .D(c_da), .QH(a_qh), .QH_n(a_qh_n)
    );

    ls165 #(.WIDTH(8)) u_b (
        .CLK(CLK), .CLR(c_clr), .SH_LD_n(c_ld_n), .CLK_INH(1'b0),
        .SER(a_qh), .D(c_db), .QH(b_qh), .QH_n(b_qh_n)
    );

    typedef struct {
        logic       sh_ld_n;
        logic       clk_inh;
        logic       ser;
        logic [7:0] d;
        logic       exp_qh;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic exp);
        check({name, ".QH"}, QH, exp);
        check({name, ".QH_n"}, QH_n, ~exp);
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic add(input logic l, input logic i, input logic s, input logic [7:0] d, input logic e);
        vec_t v;
        v.sh_ld_n = l; v.clk_inh = i; v.ser = s; v.d = d; v.exp_qh = e;
        vecs.push_back(v);
    endtask

    logic [15:0] casc_exp;

    initial begin
        // Serialise 1011_0010 MSB first, then SER=0 fills behind it.
        add(0, 0, 0, 8'b1011_0010, 1);
        add(1, 0, 0, 8'h00, 0); add(1, 0, 0, 8'h00, 1); add(1, 0, 0, 8'h00, 1);
        add(1, 0, 0, 8'h00, 0); add(1, 0, 0, 8'h00, 0); add(1, 0, 0, 8'h00, 1);
        add(1, 0, 0, 8'h00, 0); add(1, 0, 0, 8'h00, 0);
        // FF: 3 shifts, 4 holds, then shifts 4..8.
        add(0, 0, 0, 8'hFF, 1);
        for (int k = 0; k < 3; k++) add(1, 0, 0, 8'h00, 1);
        for (int k = 0; k < 4; k++) add(1, 1, 1, 8'h00, 1);
        for (int k = 0; k < 4; k++) add(1, 0, 0, 8'h00, 1);
        add(1, 0, 0, 8'h00, 0);
        // Load wins over inhibit.
        add(0, 1, 0, 8'h80, 1);
        add(1, 0, 0, 8'h00, 0);
        // Hold with inhibit keeps a 1 at H even while SER toggles.
        add(0, 0, 0, 8'h81, 1);
        add(1, 1, 0, 8'h00, 1);
        add(1, 1, 1, 8'h00, 1);

        // Async clear with the clock idle.
        #2;
        CLR = 1'b1;
        #1;
        check_out("clr_async", 1'b0);
        SH_LD_n = 1'b0;
        D = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_out($sformatf("clr_hold%0d", k), 1'b0);
        end
        CLR = 1'b0;
        SH_LD_n = 1'b1;
        c_clr = 1'b1;
        #1;
        c_clr = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            SH_LD_n = vecs[i].sh_ld_n;
            CLK_INH = vecs[i].clk_inh;
            SER = vecs[i].ser;
            D = vecs[i].d;
            tick();
            check_out($sformatf("vec%0d", i), vecs[i].exp_qh);
        end

        // Clear mid-word, then shift in ones.
        SH_LD_n = 1'b0; CLK_INH = 1'b0; SER = 1'b0; D = 8'hC3;
        tick();
        check_out("c3_load", 1'b1);
        SH_LD_n = 1'b1;
        tick();
        check_out("c3_sh1", 1'b1);
        tick();
        check_out("c3_sh2", 1'b0);
        SH_LD_n = 1'b0; D = 8'hFF;
        tick();
        check_out("ff_reload", 1'b1);
        #2;
        CLR = 1'b1;
        #1;
        check_out("clr_midword", 1'b0);
        #1;
        CLR = 1'b0;
        SH_LD_n = 1'b1; SER = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_out($sformatf("post_clr_sh%0d", k), (k == 8) ? 1'b1 : 1'b0);
        end

        // Cascade: B emits its own word, then A's word.
        casc_exp = {8'h3C, 8'hA5};
        c_da = 8'hA5; c_db = 8'h3C; c_ld_n = 1'b0;
        tick();
        check("casc_load", b_qh, casc_exp[15]);
        c_ld_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("casc_sh%0d", k), b_qh, (k < 16) ? casc_exp[15-k] : 1'b0);
        end
        check("casc_qh_n", b_qh_n, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
